// File: rtl/test_sequencer_pkg.sv
// Shared types, verdict codes and helpers for the test_sequencer harness controller.
// Optional tracing is enabled with the TEST_SEQUENCER_TRACE_EN macro (see test_sequencer.sv).
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    RUN,
    PASS,
    FAIL
  } state_t;

  // Phases of the reset-release sequencer.
  typedef enum logic [1:0] {
    PH_HOLD,
    PH_RELEASE,
    PH_DONE
  } rel_phase_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_CHANNEL = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

  // Widest channel vector the priority encoder accepts.
  localparam int MAX_CH = 64;

  function automatic int unsigned lowest_set(input logic [MAX_CH-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/test_sequencer_rst_stagger.sv
// Per-channel reset release: holds all channels for RST_HOLD edges, then frees
// them one by one every RST_STAGGER edges (all together when RST_STAGGER is 0).
module test_sequencer_rst_stagger
  import test_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int RST_HOLD    = 8,
  parameter int RST_STAGGER = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              first_release,
  output logic              all_released
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0] STAG_LAST = (RST_STAGGER > 0) ? 32'(RST_STAGGER - 1) : 32'd0;
  localparam logic ALL_AT_ONCE = (NUM_CH == 1) || (RST_STAGGER == 0);

  rel_phase_t        phase_q, phase_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;

  // The release pulses mark the edge on which the register change happens,
  // so the parent FSM moves in the same cycle as ch_reset.
  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    ch_reset_d    = ch_reset_q;
    first_release = 1'b0;
    all_released  = 1'b0;
    case (phase_q)
      PH_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d         = 32'd0;
          first_release = 1'b1;
          if (ALL_AT_ONCE) begin
            ch_reset_d   = '0;
            all_released = 1'b1;
            phase_d      = PH_DONE;
          end else begin
            ch_reset_d[0] = 1'b0;
            idx_d         = IDX_W'(1);
            phase_d       = PH_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PH_RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d             = 32'd0;
          ch_reset_d[idx_q] = 1'b0;
          idx_d             = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            all_released = 1'b1;
            phase_d      = PH_DONE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_HOLD;
      cnt_q      <= 32'd0;
      idx_q      <= '0;
      ch_reset_q <= '1;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ch_reset_q <= ch_reset_d;
    end
  end

  assign ch_reset = ch_reset_q;

endmodule

// File: rtl/test_sequencer.sv
// Test-harness controller: staggered channel reset release, RUN-cycle timeout and a
// sticky pass/fail verdict. Define TEST_SEQUENCER_TRACE_EN for simulation trace output.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 64,
  parameter int RST_HOLD    = 8,
  parameter int RST_STAGGER = 4,
  parameter int REQUIRE_ALL = 1,
  localparam int FC_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [NUM_CH-1:0] ch_success,
  input  logic [NUM_CH-1:0] ch_failure,
  output logic [NUM_CH-1:0] ch_reset,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [NUM_CH-1:0] success_mask,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [FC_W-1:0]   fail_ch,
  output logic [2:0]        dbg_state
);

  state_t            state_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic [NUM_CH-1:0] mask_q;
  logic              done_q;
  logic              pass_q;
  logic [1:0]        fail_code_q;
  logic [FC_W-1:0]   fail_ch_q;

  logic first_release;
  logic all_released;

  test_sequencer_rst_stagger #(
    .NUM_CH      (NUM_CH),
    .RST_HOLD    (RST_HOLD),
    .RST_STAGGER (RST_STAGGER)
  ) u_rst_stagger (
    .clock         (clock),
    .reset         (reset),
    .ch_reset      (ch_reset),
    .first_release (first_release),
    .all_released  (all_released)
  );

  logic [NUM_CH-1:0] sampled_mask;
  logic              pass_cond;
  logic              timeout_hit;
  logic [FC_W-1:0]   fail_idx;
  logic [CNT_W-1:0]  count_inc;

  // Success arriving on the deciding edge still counts towards the pass condition.
  // Channel vectors wider than MAX_CH are not supported by the encoder.
  always_comb begin
    sampled_mask = mask_q | ch_success;
    pass_cond    = (REQUIRE_ALL != 0) ? (&sampled_mask) : (|sampled_mask);
    timeout_hit  = (max_cycles != '0) && (cycle_count_q >= max_cycles);
    fail_idx     = FC_W'(lowest_set(MAX_CH'(ch_failure)));
    count_inc    = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HOLD;
      cycle_count_q <= '0;
      mask_q        <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FAIL_NONE;
      fail_ch_q     <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (all_released)       state_q <= RUN;
          else if (first_release) state_q <= RELEASE;
        end
        RELEASE: begin
          if (all_released) state_q <= RUN;
        end
        RUN: begin
          mask_q <= sampled_mask;
          // Failure outranks timeout, timeout outranks success; the deciding
          // edge leaves cycle_count untouched.
          if (|ch_failure) begin
            state_q     <= FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FAIL_CHANNEL;
            fail_ch_q   <= fail_idx;
          end else if (timeout_hit) begin
            state_q     <= FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FAIL_TIMEOUT;
          end else if (pass_cond) begin
            state_q <= PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            cycle_count_q <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign cycle_count  = cycle_count_q;
  assign success_mask = mask_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_code    = fail_code_q;
  assign fail_ch      = fail_ch_q;
  assign dbg_state    = state_q;

`ifdef TEST_SEQUENCER_TRACE_EN
  state_t trace_prev_q;

  always @(posedge clock) begin
    if (state_q != trace_prev_q)
      $display("[test_sequencer] t=%0t state=%s cycle_count=%0d fail_code=%0d fail_ch=%0d",
               $time, state_q.name(), cycle_count_q, fail_code_q, fail_ch_q);
    if (state_q == RUN && cycle_count_q[15:0] == 16'd0 && cycle_count_q != '0)
      $display("[test_sequencer] t=%0t heartbeat cycle_count=%0d", $time, cycle_count_q);
    trace_prev_q <= state_q;
  end
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: directed test-plan steps plus randomized
// runs checked against a cycle-indexed behavioural model of the verdict rules.
module tb_test_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [63:0] max_cycles;
  int          sel;
  logic [1:0]  succ_drv;
  logic [1:0]  fail_drv;

  int checks   = 0;
  int failures = 0;

  // DUT A: defaults (NUM_CH=2, HOLD=8, STAGGER=4, REQUIRE_ALL=1)
  logic [1:0]  a_succ, a_fail, a_ch_reset, a_mask, a_code;
  logic [63:0] a_cnt;
  logic        a_done, a_pass;
  logic [0:0]  a_ch;
  logic [2:0]  a_dbg;
  // DUT B: NUM_CH=2, HOLD=3, STAGGER=2, REQUIRE_ALL=0
  logic [1:0]  b_succ, b_fail, b_ch_reset, b_mask, b_code;
  logic [63:0] b_cnt;
  logic        b_done, b_pass;
  logic [0:0]  b_ch;
  logic [2:0]  b_dbg;
  // DUT C: NUM_CH=4, HOLD=5, STAGGER=0
  logic [3:0]  c_succ, c_fail, c_ch_reset, c_mask;
  logic [1:0]  c_code, c_ch;
  logic [63:0] c_cnt;
  logic        c_done, c_pass;
  logic [2:0]  c_dbg;

  assign a_succ = (sel == 0) ? succ_drv : 2'b00;
  assign a_fail = (sel == 0) ? fail_drv : 2'b00;
  assign b_succ = (sel == 1) ? succ_drv : 2'b00;
  assign b_fail = (sel == 1) ? fail_drv : 2'b00;
  assign c_succ = 4'h0;
  assign c_fail = 4'h0;

  test_sequencer #(.NUM_CH(2), .CNT_W(64), .RST_HOLD(8), .RST_STAGGER(4), .REQUIRE_ALL(1)) dut_a (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .ch_success(a_succ), .ch_failure(a_fail), .ch_reset(a_ch_reset),
    .cycle_count(a_cnt), .success_mask(a_mask), .done(a_done), .pass(a_pass),
    .fail_code(a_code), .fail_ch(a_ch), .dbg_state(a_dbg));

  test_sequencer #(.NUM_CH(2), .CNT_W(64), .RST_HOLD(3), .RST_STAGGER(2), .REQUIRE_ALL(0)) dut_b (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .ch_success(b_succ), .ch_failure(b_fail), .ch_reset(b_ch_reset),
    .cycle_count(b_cnt), .success_mask(b_mask), .done(b_done), .pass(b_pass),
    .fail_code(b_code), .fail_ch(b_ch), .dbg_state(b_dbg));

  test_sequencer #(.NUM_CH(4), .CNT_W(64), .RST_HOLD(5), .RST_STAGGER(0), .REQUIRE_ALL(1)) dut_c (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .ch_success(c_succ), .ch_failure(c_fail), .ch_reset(c_ch_reset),
    .cycle_count(c_cnt), .success_mask(c_mask), .done(c_done), .pass(c_pass),
    .fail_code(c_code), .fail_ch(c_ch), .dbg_state(c_dbg));

  // Observed outputs of whichever two-channel DUT is selected
  logic [1:0]  o_ch_reset, o_mask, o_code;
  logic [63:0] o_cnt;
  logic        o_done, o_pass;
  logic [0:0]  o_ch;

  always_comb begin
    if (sel == 0) begin
      o_ch_reset = a_ch_reset; o_mask = a_mask; o_code = a_code;
      o_cnt = a_cnt; o_done = a_done; o_pass = a_pass; o_ch = a_ch;
    end else begin
      o_ch_reset = b_ch_reset; o_mask = b_mask; o_code = b_code;
      o_cnt = b_cnt; o_done = b_done; o_pass = b_pass; o_ch = b_ch;
    end
  end

  logic [1:0] succ_ev[256];
  logic [1:0] fail_ev[256];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ev();
    for (int k = 0; k < 256; k++) begin
      succ_ev[k] = 2'b00;
      fail_ev[k] = 2'b00;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ch_reset"}, 64'(o_ch_reset), 64'h3);
    chk({tag, ".cycle_count"}, o_cnt, 64'd0);
    chk({tag, ".success_mask"}, 64'(o_mask), 64'd0);
    chk({tag, ".done"}, 64'(o_done), 64'd0);
    chk({tag, ".pass"}, 64'(o_pass), 64'd0);
    chk({tag, ".fail_code"}, 64'(o_code), 64'd0);
    chk({tag, ".fail_ch"}, 64'(o_ch), 64'd0);
  endtask

  // Holds reset for two edges, checks reset values, then deasserts #1 after an
  // edge so the next rising edge is edge 1.
  task automatic do_reset();
    succ_drv = 2'b00;
    fail_drv = 2'b00;
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  // Full sequence on DUT s: release schedule (with random noise on the channel
  // inputs, which must be ignored), then the RUN events in succ_ev/fail_ev.
  task automatic run_case(input int s, input logic [63:0] mc);
    int h, st, e, vk;
    bit found, ra;
    logic [1:0] m, exp_code, exp_mask, exp_rst;
    logic exp_pass, exp_ch;

    sel = s;
    max_cycles = mc;
    do_reset();
    h  = (s == 0) ? 8 : 3;
    st = (s == 0) ? 4 : 2;
    ra = (s == 0);
    e  = h + st;

    for (int n = 1; n <= e; n++) begin
      succ_drv = 2'($urandom_range(0, 3));
      fail_drv = 2'($urandom_range(0, 3));
      tick();
      exp_rst = {(n < h + st), (n < h)};
      chk("release.ch_reset", 64'(o_ch_reset), 64'(exp_rst));
      chk("release.done", 64'(o_done), 64'd0);
    end
    chk("run_entry.cycle_count", o_cnt, 64'd0);
    chk("run_entry.success_mask", 64'(o_mask), 64'd0);

    // Reference model: walk the RUN cycles, cycle k being the one where cycle_count reads k.
    found = 0; vk = 0; m = 2'b00;
    exp_code = 2'd0; exp_pass = 1'b0; exp_ch = 1'b0; exp_mask = 2'b00;
    for (int k = 0; k < 256 && !found; k++) begin
      m = m | succ_ev[k];
      if (fail_ev[k] != 2'b00) begin
        found = 1; vk = k; exp_code = 2'd1; exp_ch = fail_ev[k][0] ? 1'b0 : 1'b1;
      end else if (mc != 0 && 64'(k) >= mc) begin
        found = 1; vk = k; exp_code = 2'd2;
      end else if (ra ? (m == 2'b11) : (m != 2'b00)) begin
        found = 1; vk = k; exp_pass = 1'b1;
      end
      exp_mask = m;
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL model_verdict observed=none expected=verdict");
      return;
    end

    for (int k = 0; k < vk; k++) begin
      succ_drv = succ_ev[k];
      fail_drv = fail_ev[k];
      tick();
      chk("run.cycle_count", o_cnt, 64'(k + 1));
      chk("run.done", 64'(o_done), 64'd0);
    end
    succ_drv = succ_ev[vk];
    fail_drv = fail_ev[vk];
    tick();
    chk("verdict.done", 64'(o_done), 64'd1);
    chk("verdict.pass", 64'(o_pass), 64'(exp_pass));
    chk("verdict.fail_code", 64'(o_code), 64'(exp_code));
    if (exp_code == 2'd1) chk("verdict.fail_ch", 64'(o_ch), 64'(exp_ch));
    chk("verdict.cycle_count", o_cnt, 64'(vk));
    chk("verdict.success_mask", 64'(o_mask), 64'(exp_mask));

    for (int k = 0; k < 3; k++) begin
      succ_drv = 2'($urandom_range(0, 3));
      fail_drv = 2'($urandom_range(0, 3));
      tick();
    end
    chk("frozen.cycle_count", o_cnt, 64'(vk));
    chk("frozen.success_mask", 64'(o_mask), 64'(exp_mask));
    chk("frozen.done", 64'(o_done), 64'd1);
    chk("frozen.fail_code", 64'(o_code), 64'(exp_code));
  endtask

  initial begin
    reset = 1'b1;
    sel = 0;
    max_cycles = 64'd0;
    succ_drv = 2'b00;
    fail_drv = 2'b00;

    // Both channels must succeed: pulses at RUN cycles 10 and 20
    clear_ev();
    succ_ev[10] = 2'b01;
    succ_ev[20] = 2'b10;
    run_case(0, 64'd0);

    // Timeout after 100 RUN cycles with no success
    clear_ev();
    run_case(0, 64'd100);

    // Failure on ch1 beats success on ch0 on the same edge (any-success mode)
    clear_ev();
    fail_ev[7] = 2'b10;
    succ_ev[7] = 2'b01;
    run_case(1, 64'd0);

    // Both channels failing at once reports the lower index
    clear_ev();
    fail_ev[4] = 2'b11;
    run_case(0, 64'd50);

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 256; k++) begin
        succ_ev[k] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        fail_ev[k] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      run_case(int'($urandom_range(0, 1)), 64'($urandom_range(10, 120)));
    end

    // Asynchronous reset mid-RUN, then a clean restart of the release sequence
    sel = 0;
    max_cycles = 64'd0;
    do_reset();
    for (int n = 0; n < 17; n++) tick();
    chk("pre_async.cycle_count", o_cnt, 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk("restart.ch_reset", 64'(o_ch_reset), 64'({(n < 12), (n < 8)}));
    end
    chk("restart.cycle_count", o_cnt, 64'd0);

    // Four channels released together with zero stagger
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("stagger0.ch_reset", 64'(c_ch_reset), (n < 5) ? 64'hF : 64'h0);
      chk("stagger0.cycle_count", c_cnt, (n <= 5) ? 64'd0 : 64'(n - 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
